// File: rtl/arith_pipe_hs.sv
// arith_pipe_hs: three-stage valid/ready arithmetic pipeline.
// Default mode computes F = ((A+B)+(C-D))*D. Each stage stalls only when it
// holds a valid item that downstream cannot take, so the pipe runs at one
// item per clock. D and the mode bits travel with their own item.
module arith_pipe_hs #(
  parameter int W  = 10,
  parameter int PW = 2*W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] f,
  output logic          busy
);

  // Wide enough to hold the full W*W product, or PW if PW is larger.
  localparam int MW = (PW > 2*W) ? PW : 2*W;

  logic          v1_q, v2_q, v3_q;
  logic          en1, en2, en3;

  logic [W-1:0]  x1_q, x2_q, d1_q;
  logic [1:0]    op1_q;
  logic [W-1:0]  x1_d, x2_d;

  logic [W-1:0]  x3_q, d2_q;
  logic          byp2_q;
  logic [W-1:0]  x3_d;

  logic [PW-1:0] f_q, f_d;

  // Stage enables: a stage may advance if it is empty or its successor advances.
  always_comb begin
    en3 = !v3_q | out_ready;
    en2 = !v2_q | en3;
    en1 = !v1_q | en2;
  end

  assign in_ready  = en1;
  assign out_valid = v3_q;
  assign f         = f_q;
  assign busy      = v1_q | v2_q | v3_q;

  // Next-state datapath for all three stages (all arithmetic wraps at 2^W
  // except the final product, which is truncated to PW bits).
  always_comb begin
    x1_d = a + b;
    x2_d = c - d;
    x3_d = op1_q[0] ? (x1_q - x2_q) : (x1_q + x2_q);
    f_d  = byp2_q ? PW'(x3_q) : PW'(MW'(x3_q) * MW'(d2_q));
  end

  // Stage 1: data loads only with a valid input so idle cycles leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      x1_q  <= '0;
      x2_q  <= '0;
      d1_q  <= '0;
      op1_q <= '0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        x1_q  <= x1_d;
        x2_q  <= x2_d;
        d1_q  <= d;
        op1_q <= op;
      end
    end
  end

  // Stage 2: add/subtract the two partial sums, carry D and bypass flag along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      x3_q   <= '0;
      d2_q   <= '0;
      byp2_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        x3_q   <= x3_d;
        d2_q   <= d1_q;
        byp2_q <= op1_q[1];
      end
    end
  end

  // Stage 3: multiply by the item's own D (or bypass); gating on v2 keeps f
  // at zero until the first real result arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q <= 1'b0;
      f_q  <= '0;
    end else if (en3) begin
      v3_q <= v2_q;
      if (v2_q) f_q <= f_d;
    end
  end

endmodule

// File: tb/tb_arith_pipe_hs.sv
// Scoreboard bench for arith_pipe_hs: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_arith_pipe_hs;
  localparam int W  = 10;
  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
  logic [1:0]    op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] f;
  logic          busy;

  arith_pipe_hs #(.W(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] f;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;

  // Directed vectors: a, b, c, d, op, expected f
  int va[16] = '{5, 5, 5, 5, 1000, 1023, 1023, 1, 1, 1, 10, 7, 100, 2, 0, 9};
  int vb[16] = '{3, 3, 3, 3, 100,  0,    0,    1, 1, 1, 20, 0, 200, 2, 0, 9};
  int vc[16] = '{10,10,10,10,0,    0,    1023, 1, 1, 1, 30, 9, 50,  8, 0, 9};
  int vd[16] = '{4, 4, 4, 4, 1,    1023, 1023, 2, 7, 0, 5,  3, 10,  8, 1023, 9};
  int vo[16] = '{0, 1, 2, 3, 0,    0,    0,    0, 0, 0, 0,  1, 2,   3, 0, 0};
  int ve[16] = '{56,8, 14,2, 75,   0, 1046529, 2, 7140, 0, 275, 3, 340, 4, 1023, 162};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive vectors lo..hi in order, each held until accepted (bounded wait).
  task automatic run_vecs(int lo, int hi, bit lat);
    for (int i = lo; i <= hi; i++) begin
      bit done = 1'b0;
      a = W'(va[i]); b = W'(vb[i]); c = W'(vc[i]); d = W'(vd[i]); op = 2'(vo[i]);
      in_valid = 1'b1;
      for (int t = 0; t < 60 && !done; t++) begin
        @(negedge clk);
        if (in_ready) begin
          exp_t e;
          e.f = PW'(ve[i]); e.acc = cyc; e.lat = lat;
          sb.push_back(e);
          accepted++;
          done = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!done) chk("accept_timeout", 64'(done), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  // Monitor: every output handshake must match the oldest outstanding item.
  exp_t me;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(f), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        me = sb.pop_front();
        chk("f", 64'(f), 64'(me.f));
        if (me.lat) chk("latency", 64'(cyc - me.acc), 64'd3);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_f",         64'(f),         64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. Basic, 3-cycle latency, single-cycle out_valid
    run_vecs(0, 0, 1'b1);
    wait_drain();
    @(negedge clk);
    chk("pulse_len", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // 2-4. Modes, wrap-around, D alignment, back-to-back
    run_vecs(1, 9, 1'b1);
    wait_drain();
    @(posedge clk); #1;

    // 5. Backpressure: only three items fit while the consumer stalls
    out_ready = 1'b0;
    accepted  = 0;
    fork
      run_vecs(10, 14, 1'b0);
    join_none
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted",  64'(accepted),  64'd3);
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_busy",      64'(busy),      64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stream", 64'(out_valid), 64'd1);
    end
    begin
      bit all_in = 1'b0;
      for (int t = 0; t < 100 && !all_in; t++) begin
        @(negedge clk);
        if (accepted == 5) all_in = 1'b1;
      end
      chk("bp_all_accepted", 64'(accepted), 64'd5);
    end
    wait_drain();
    @(posedge clk); #1;

    // 6. Asynchronous reset with two items in flight
    run_vecs(15, 15, 1'b0);
    run_vecs(11, 11, 1'b0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy",      64'(busy),      64'd0);
    chk("arst_f",         64'(f),         64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vecs(0, 0, 1'b1);
    wait_drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
